// File: rtl/apb_pkg.sv
// Shared types for the APB master arbiter: FSM states and the captured request bundle.
// Capture fields are sized for the widest supported bus; narrower instances use the low bits.
package apb_pkg;

    localparam int unsigned APB_PROT_WIDTH     = 3;
    localparam int unsigned APB_MAX_ADDR_WIDTH = 64;
    localparam int unsigned APB_MAX_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } apb_arb_state_t;

    typedef struct packed {
        logic [APB_MAX_ADDR_WIDTH-1:0]   addr;
        logic                            write;
        logic [APB_MAX_DATA_WIDTH-1:0]   wdata;
        logic [APB_MAX_DATA_WIDTH/8-1:0] strb;
        logic [APB_PROT_WIDTH-1:0]       prot;
    } apb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above ptr_i, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int unsigned IdxW = $clog2(N);

    logic [N-1:0] mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] sel;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (i >= 32'(ptr_i));
        end
        req_hi = req_i & mask;
        // Requests at or above the pointer take precedence; otherwise wrap to the bottom.
        sel    = (|req_hi) ? req_hi : req_i;
    end

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any_o && sel[i]) begin
                any_o    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters,
// sequencing SETUP/ACCESS itself and aborting transfers whose PREADY never arrives.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr_i,
    input  logic [NUM_REQ-1:0]                  req_write_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]     req_strb_i,
    input  logic [NUM_REQ*APB_PROT_WIDTH-1:0]   req_prot_i,

    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    input  logic [NUM_REQ-1:0]                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
    output logic                                rsp_err_o,
    output logic [$clog2(NUM_REQ)-1:0]          grant_id_o,

    output logic [ADDR_WIDTH-1:0]               m_apb_paddr_o,
    output logic                                m_apb_psel_o,
    output logic                                m_apb_penable_o,
    output logic                                m_apb_pwrite_o,
    output logic [DATA_WIDTH-1:0]               m_apb_pwdata_o,
    output logic [DATA_WIDTH/8-1:0]             m_apb_pstrb_o,
    output logic [APB_PROT_WIDTH-1:0]           m_apb_pprot_o,
    input  logic [DATA_WIDTH-1:0]               m_apb_prdata_i,
    input  logic                                m_apb_pready_i,
    input  logic                                m_apb_pslverr_i
);

    localparam int unsigned IdW       = $clog2(NUM_REQ);
    localparam int unsigned StrbW     = DATA_WIDTH / 8;
    localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CntW      = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    if (NUM_REQ < 2 || (DATA_WIDTH % 8) != 0 || ADDR_WIDTH > APB_MAX_ADDR_WIDTH ||
        DATA_WIDTH > APB_MAX_DATA_WIDTH) begin : gen_bad_params
        $error("apb_master_arbiter: unsupported parameter set");
    end

    apb_arb_state_t        state_q, state_d;
    apb_req_t              cap_q, cap_d;
    logic [IdW-1:0]        gid_q, gid_d;
    logic [IdW-1:0]        ptr_q, ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IdW-1:0]        arb_idx;
    logic                  arb_any;
    logic                  timeout_hit;
    logic                  unused_cap;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        gid_d       = gid_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        timeout_hit = TimeoutEn && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    cap_d = '0;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            cap_d.addr[ADDR_WIDTH-1:0]  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                            cap_d.write                 = req_write_i[i];
                            cap_d.wdata[DATA_WIDTH-1:0] = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                            cap_d.strb[StrbW-1:0]       = req_strb_i[i*StrbW +: StrbW];
                            cap_d.prot = req_prot_i[i*APB_PROT_WIDTH +: APB_PROT_WIDTH];
                        end
                    end
                    gid_d   = arb_idx;
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                // PREADY takes priority over a timeout landing in the same cycle.
                if (m_apb_pready_i) begin
                    rdata_d = cap_q.write ? '0 : m_apb_prdata_i;
                    err_d   = m_apb_pslverr_i;
                    state_d = StResp;
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (timeout_hit) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (rsp_ready_i[gid_q]) begin
                    ptr_d   = (gid_q == IdW'(NUM_REQ - 1)) ? '0 : gid_q + IdW'(1);
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        psel_d    = (state_d == StSetup) || (state_d == StAccess);
        penable_d = (state_d == StAccess);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cap_q     <= '0;
            gid_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            gid_q     <= gid_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    // req_ready is combinational from the arbiter, so it is gated by reset as well.
    always_comb begin
        req_ready_o = (rst_n && state_q == StIdle) ? arb_gnt : '0;
        rsp_valid_o = '0;
        if (state_q == StResp) begin
            rsp_valid_o[gid_q] = 1'b1;
        end
    end

    assign rsp_rdata_o     = rdata_q;
    assign rsp_err_o       = err_q;
    assign grant_id_o      = gid_q;

    assign m_apb_psel_o    = psel_q;
    assign m_apb_penable_o = penable_q;
    assign m_apb_paddr_o   = cap_q.addr[ADDR_WIDTH-1:0];
    assign m_apb_pwrite_o  = cap_q.write;
    assign m_apb_pwdata_o  = cap_q.wdata[DATA_WIDTH-1:0];
    assign m_apb_pstrb_o   = cap_q.strb[StrbW-1:0];
    assign m_apb_pprot_o   = cap_q.prot;

    // Upper capture bits beyond the configured widths are constant zero.
    assign unused_cap = ^cap_q;

endmodule
